// File: rtl/adc_poll_scheduler.sv
// Polls up to 8 analog mux channels through the serial ADC receiver and presents
// channel-tagged samples on a valid/ack port; lost conversions are flagged and counted.
module adc_poll_scheduler #(
    parameter logic [7:0] SETTLE    = 8'd16,
    parameter logic [3:0] REQ_WIDTH = 4'd4,
    parameter logic [7:0] TIMEOUT   = 8'd200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    input  logic [7:0]  chMask,
    input  logic        spiReady,
    input  logic [11:0] spiData,
    output logic [2:0]  muxSel,
    output logic        dataRequest,
    output logic [15:0] outData,
    output logic        outValid,
    input  logic        outAck,
    output logic        busy,
    output logic        frameDone,
    output logic [7:0]  errCnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_NEXT
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [7:0]  mask, mask_nxt;
    logic        spi_ready_d;
    logic        rdy_rise;
    logic [2:0]  mux_nxt;
    logic        req_nxt;
    logic [15:0] data_nxt;
    logic        valid_nxt;
    logic        busy_nxt;
    logic        done_nxt;
    logic [7:0]  err_nxt;
    logic [3:0]  low_ch;
    logic [3:0] hi_ch;

    // Returns {found, index} of the lowest set bit of m at or above position from.
    function automatic logic [3:0] lowest_from(input logic [7:0] m, input logic [3:0] from);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (4'(i) >= from)) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

    assign rdy_rise = spiReady & ~spi_ready_d;
    assign low_ch   = lowest_from(chMask, 4'd0);
    assign hi_ch    = lowest_from(mask, 4'({1'b0, muxSel}) + 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            mask        <= 8'd0;
            spi_ready_d <= 1'b0;
            muxSel      <= 3'd0;
            dataRequest <= 1'b0;
            outData     <= 16'd0;
            outValid    <= 1'b0;
            busy        <= 1'b0;
            frameDone   <= 1'b0;
            errCnt      <= 8'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            mask        <= mask_nxt;
            spi_ready_d <= spiReady;
            muxSel      <= mux_nxt;
            dataRequest <= req_nxt;
            outData     <= data_nxt;
            outValid    <= valid_nxt;
            busy        <= busy_nxt;
            frameDone   <= done_nxt;
            errCnt      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mask_nxt  = mask;
        mux_nxt   = muxSel;
        req_nxt   = dataRequest;
        data_nxt  = outData;
        valid_nxt = outValid;
        done_nxt  = 1'b0;
        err_nxt   = errCnt;

        case (state)
            S_IDLE: begin
                if (start) begin
                    mask_nxt = chMask;
                    if (low_ch[3]) begin
                        mux_nxt   = low_ch[2:0];
                        cnt_nxt   = 8'd0;
                        state_nxt = S_SELECT;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            S_SELECT: begin
                if (cnt == SETTLE) begin
                    cnt_nxt   = 8'd0;
                    req_nxt   = 1'b1;
                    state_nxt = S_REQ;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_REQ: begin
                if (cnt == 8'(REQ_WIDTH - 4'd1)) begin
                    cnt_nxt   = 8'd0;
                    req_nxt   = 1'b0;
                    state_nxt = S_WAIT;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_WAIT: begin
                // A ready edge in the same cycle as the timeout still delivers the sample.
                if (rdy_rise) begin
                    data_nxt  = {1'b0, muxSel, spiData};
                    valid_nxt = 1'b1;
                    state_nxt = S_OUT;
                end else if (cnt == TIMEOUT - 8'd1) begin
                    data_nxt  = {1'b1, muxSel, 12'h000};
                    valid_nxt = 1'b1;
                    if (errCnt != 8'hFF) begin
                        err_nxt = errCnt + 8'd1;
                    end
                    state_nxt = S_OUT;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_OUT: begin
                if (outValid && outAck) begin
                    valid_nxt = 1'b0;
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (hi_ch[3]) begin
                    mux_nxt   = hi_ch[2:0];
                    cnt_nxt   = 8'd0;
                    state_nxt = S_SELECT;
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                    if (continuous) begin
                        mask_nxt = chMask;
                        if (low_ch[3]) begin
                            mux_nxt   = low_ch[2:0];
                            cnt_nxt   = 8'd0;
                            state_nxt = S_SELECT;
                        end
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_adc_poll_scheduler.sv
// Directed bench for adc_poll_scheduler with a simple ADC receiver model.
module tb_adc_poll_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        continuous;
    logic [7:0]  chMask;
    logic        spiReady;
    logic [11:0] spiData;
    logic [2:0]  muxSel;
    logic        dataRequest;
    logic [15:0] outData;
    logic        outValid;
    logic        outAck;
    logic        busy;
    logic        frameDone;
    logic [7:0]  errCnt;

    int n_tests = 0;
    int n_fail  = 0;

    // receiver model state
    logic       rx_silent = 1'b0;
    logic       rx_mode   = 1'b0;
    logic       rx_rdy    = 1'b0;
    logic       inj_rdy   = 1'b0;
    logic [11:0] rx_data  = 12'h000;
    int         rx_cnt    = 0;
    logic       req_prev  = 1'b0;
    int         req_cnt   = 0;
    int         frame_cnt = 0;

    assign spiReady = rx_rdy | inj_rdy;
    assign spiData  = rx_data;

    always #5 clk = ~clk;

    adc_poll_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .continuous  (continuous),
        .chMask      (chMask),
        .spiReady    (spiReady),
        .spiData     (spiData),
        .muxSel      (muxSel),
        .dataRequest (dataRequest),
        .outData     (outData),
        .outValid    (outValid),
        .outAck      (outAck),
        .busy        (busy),
        .frameDone   (frameDone),
        .errCnt      (errCnt)
    );

    // Receiver: answers a request rise with a 3-cycle ready strobe a few cycles later.
    always @(negedge clk) begin
        if (frameDone) frame_cnt++;
        if (dataRequest && !req_prev) begin
            req_cnt++;
            if (!rx_silent) begin
                rx_cnt  = 1;
                rx_data = rx_mode ? (12'h100 + 12'(muxSel)) : 12'hABC;
            end
        end else if (rx_cnt > 0) begin
            rx_cnt++;
        end
        rx_rdy = (rx_cnt >= 6) && (rx_cnt < 9);
        if (rx_cnt >= 9) rx_cnt = 0;
        req_prev = dataRequest;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!outValid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(outValid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic ack_out();
        @(negedge clk);
        outAck = 1'b1;
        @(negedge clk);
        outAck = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] m);
        chMask = m;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mux"},   32'(muxSel),      32'd0);
        check({tag, "_req"},   32'(dataRequest), 32'd0);
        check({tag, "_data"},  32'(outData),     32'd0);
        check({tag, "_valid"}, 32'(outValid),    32'd0);
        check({tag, "_busy"},  32'(busy),        32'd0);
        check({tag, "_done"},  32'(frameDone),   32'd0);
        check({tag, "_err"},   32'(errCnt),      32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_hi;
        int hi_len;
        int f0;
        int r0;
        int n;
        logic [15:0] d0;
        logic [15:0] exp_seq [3];

        reset = 1'b1; start = 1'b0; continuous = 1'b0; chMask = 8'h00; outAck = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // single channel: request timing and sample tagging
        rx_mode = 1'b0;
        f0 = frame_cnt;
        chMask = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_hi = -1;
        hi_len = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (dataRequest) begin
                if (first_hi < 0) first_hi = k;
                hi_len++;
            end
        end
        check("t1_req_start", 32'(first_hi), 32'd17);
        check("t1_req_width", 32'(hi_len), 32'd4);
        check("t1_mux", 32'(muxSel), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        wait_valid("t1_valid");
        check("t1_data", 32'(outData), 32'h0ABC);
        ack_out();
        wait_idle("t1_idle");
        check("t1_frames", 32'(frame_cnt - f0), 32'd1);

        // sparse mask 0xA4: ascending ch2, ch5, ch7
        rx_mode = 1'b1;
        f0 = frame_cnt;
        r0 = req_cnt;
        exp_seq[0] = 16'h2102; exp_seq[1] = 16'h5105; exp_seq[2] = 16'h7107;
        pulse_start(8'hA4);
        for (int i = 0; i < 3; i++) begin
            wait_valid($sformatf("t2_valid%0d", i));
            check($sformatf("t2_data%0d", i), 32'(outData), 32'(exp_seq[i]));
            ack_out();
        end
        wait_idle("t2_idle");
        check("t2_reqs", 32'(req_cnt - r0), 32'd3);
        check("t2_frames", 32'(frame_cnt - f0), 32'd1);

        // silent receiver: timeout after 200 WAIT cycles
        rx_silent = 1'b1;
        pulse_start(8'h08);
        n = 0;
        while (!dataRequest && n < 100) begin @(negedge clk); n++; end
        while (dataRequest && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (!outValid && n < 400) begin @(negedge clk); n++; end
        check("t3_wait_len", 32'(n), 32'd200);
        check("t3_data", 32'(outData), 32'hB000);
        check("t3_err", 32'(errCnt), 32'd1);
        ack_out();
        wait_idle("t3_idle");
        for (int f = 2; f <= 256; f++) begin
            pulse_start(8'h08);
            wait_valid("t3_loop_valid");
            ack_out();
            wait_idle("t3_loop_idle");
            if (f == 255) check("t3_err255", 32'(errCnt), 32'd255);
        end
        check("t3_err_sat", 32'(errCnt), 32'd255);
        rx_silent = 1'b0;

        // back-pressure: output held stable, extra ready pulses ignored
        rx_mode = 1'b0;
        f0 = frame_cnt;
        pulse_start(8'h01);
        wait_valid("t4_valid");
        d0 = outData;
        check("t4_data", 32'(d0), 32'h0ABC);
        r0 = req_cnt;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            inj_rdy = (i == 10) || (i == 11) || (i == 30) || (i == 31);
            check("t4_hold_valid", 32'(outValid), 32'd1);
            check("t4_hold_data", 32'(outData), 32'(d0));
        end
        inj_rdy = 1'b0;
        check("t4_no_req", 32'(req_cnt - r0), 32'd0);
        ack_out();
        wait_idle("t4_idle");
        check("t4_frames", 32'(frame_cnt - f0), 32'd1);

        // continuous mode with mid-frame mask change
        rx_mode = 1'b1;
        continuous = 1'b1;
        f0 = frame_cnt;
        r0 = req_cnt;
        pulse_start(8'h03);
        wait_valid("t5_v0");
        check("t5_d0", 32'(outData), 32'h0100);
        ack_out();
        wait_valid("t5_v1");
        check("t5_d1", 32'(outData), 32'h1101);
        chMask = 8'h04;
        ack_out();
        wait_valid("t5_v2");
        check("t5_d2", 32'(outData), 32'h2102);
        continuous = 1'b0;
        ack_out();
        wait_idle("t5_idle");
        check("t5_frames", 32'(frame_cnt - f0), 32'd2);
        check("t5_reqs", 32'(req_cnt - r0), 32'd3);

        // empty mask: immediate frameDone, no request
        r0 = req_cnt;
        pulse_start(8'h00);
        check("t5_empty_done", 32'(frameDone), 32'd1);
        @(negedge clk);
        check("t5_empty_done_off", 32'(frameDone), 32'd0);
        check("t5_empty_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check("t5_empty_noreq", 32'(req_cnt - r0), 32'd0);

        // reset during WAIT
        rx_silent = 1'b1;
        pulse_start(8'h01);
        n = 0;
        while (!dataRequest && n < 100) begin @(negedge clk); n++; end
        while (dataRequest && n < 200) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        check("t6_in_wait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("t6_wait_rst");
        rx_silent = 1'b0;
        @(negedge clk);

        // reset during OUT, then resume from the lowest channel
        pulse_start(8'h02);
        wait_valid("t6_out_valid");
        check("t6_out_data", 32'(outData), 32'h1101);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("t6_out_rst");
        @(negedge clk);
        pulse_start(8'h06);
        wait_valid("t6_r_v0");
        check("t6_r_d0", 32'(outData), 32'h1101);
        ack_out();
        wait_valid("t6_r_v1");
        check("t6_r_d1", 32'(outData), 32'h2102);
        ack_out();
        wait_idle("t6_r_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
